puf_soc_resp_sampler: RTL and testbench

//  Scan controller feeding puf_soc_mux: drives its select, waits for the selected PUF

---
 rtl/puf_soc_resp_sampler.sv | 182 ++++++++++++++++++
 tb/tb_puf_soc_resp_sampler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/puf_soc_resp_sampler.sv
// Scan controller for puf_soc_mux: steps the select, waits for the cell to settle, then
// samples each channel into a response word returned over valid/ready. Optional build
// macro PUF_SOC_MAJ_VOTE_EN enables 3-sample majority voting with an unstable-channel count.
module puf_soc_resp_sampler #(
    parameter int N_BIT      = 1,
    parameter int MUX_SZ     = 16,
    parameter int SETTLE_CYC = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    output logic                      o_busy,
    output logic [$clog2(MUX_SZ)-1:0] o_sel_mux,
    input  logic [N_BIT-1:0]          i_mux,
    output logic [MUX_SZ*N_BIT-1:0]   o_resp,
    output logic                      o_resp_valid,
    input  logic                      i_resp_ready,
    output logic [$clog2(MUX_SZ):0]   o_unstable_cnt
);

    localparam int SEL_W = $clog2(MUX_SZ);
    localparam int CNT_W = 8;
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(MUX_SZ - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t                    state_reg, state_next;
    logic [CNT_W-1:0]          cnt_reg, cnt_next;
    logic [SEL_W-1:0]          sel_reg, sel_next;
    logic [MUX_SZ*N_BIT-1:0]   resp_reg, resp_next;
    logic                      valid_reg, valid_next;
    logic                      busy_reg, busy_next;

    // sample_last marks the cycle in SAMPLE whose edge commits the slot value
    logic                      sample_last;
    logic [N_BIT-1:0]          sample_val;
    logic                      start_accept;

    assign start_accept = (state_reg == ST_IDLE) && i_start;

`ifdef PUF_SOC_MAJ_VOTE_EN
    logic [1:0]       phase_reg, phase_next;
    logic [N_BIT-1:0] vote0_reg, vote1_reg;
    logic [SEL_W:0]   unst_reg, unst_next;
    logic [N_BIT-1:0] maj_val;
    logic             disagree;
    genvar gi;

    // The third vote is taken live from i_mux on the committing edge
    generate
        for (gi = 0; gi < N_BIT; gi++) begin : g_maj
            assign maj_val[gi] = (vote0_reg[gi] & vote1_reg[gi]) |
                                 (vote0_reg[gi] & i_mux[gi])     |
                                 (vote1_reg[gi] & i_mux[gi]);
        end
    endgenerate

    assign disagree    = |((vote0_reg ^ vote1_reg) | (vote1_reg ^ i_mux));
    assign sample_last = (phase_reg == 2'd2);
    assign sample_val  = maj_val;

    always_comb begin
        phase_next = phase_reg;
        unst_next  = unst_reg;
        if (start_accept) begin
            phase_next = 2'd0;
            unst_next  = '0;
        end else if (state_reg == ST_SAMPLE) begin
            phase_next = sample_last ? 2'd0 : phase_reg + 2'd1;
            if (sample_last && disagree) begin
                unst_next = unst_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            phase_reg <= 2'd0;
            vote0_reg <= '0;
            vote1_reg <= '0;
            unst_reg  <= '0;
        end else begin
            phase_reg <= phase_next;
            unst_reg  <= unst_next;
            if (state_reg == ST_SAMPLE && phase_reg == 2'd0) begin
                vote0_reg <= i_mux;
            end
            if (state_reg == ST_SAMPLE && phase_reg == 2'd1) begin
                vote1_reg <= i_mux;
            end
        end
    end

    assign o_unstable_cnt = unst_reg;
`else
    assign sample_last    = 1'b1;
    assign sample_val     = i_mux;
    assign o_unstable_cnt = '0;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sel_next   = sel_reg;
        resp_next  = resp_reg;
        valid_next = valid_reg;
        busy_next  = busy_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_start) begin
                    state_next = ST_SETTLE;
                    sel_next   = '0;
                    resp_next  = '0;
                    cnt_next   = CNT_LOAD;
                    busy_next  = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_reg == '0) begin
                    state_next = ST_SAMPLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (sample_last) begin
                    resp_next[sel_reg*N_BIT +: N_BIT] = sample_val;
                    if (sel_reg == SEL_LAST) begin
                        state_next = ST_DONE;
                        valid_next = 1'b1;
                    end else begin
                        // Select only moves on SETTLE entry so the mux sees a stable input
                        sel_next   = sel_reg + 1'b1;
                        cnt_next   = CNT_LOAD;
                        state_next = ST_SETTLE;
                    end
                end
            end
            ST_DONE: begin
                if (i_resp_ready) begin
                    state_next = ST_IDLE;
                    valid_next = 1'b0;
                    busy_next  = 1'b0;
                    sel_next   = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            sel_reg   <= '0;
            resp_reg  <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sel_reg   <= sel_next;
            resp_reg  <= resp_next;
            valid_reg <= valid_next;
            busy_reg  <= busy_next;
        end
    end

    assign o_busy       = busy_reg;
    assign o_sel_mux    = sel_reg;
    assign o_resp       = resp_reg;
    assign o_resp_valid = valid_reg;

endmodule

// File: tb/tb_puf_soc_resp_sampler.sv
// Randomized bench for puf_soc_resp_sampler; the reference derives expected words, select
// timing and latency from the scan schedule (SETTLE_CYC settle cycles plus K sample cycles).
module tb_puf_soc_resp_sampler;

    localparam int N_BIT      = 1;
    localparam int MUX_SZ     = 16;
    localparam int SETTLE_CYC = 4;
    localparam int SEL_W      = 4;
`ifdef PUF_SOC_MAJ_VOTE_EN
    localparam int K = 3;
`else
    localparam int K = 1;
`endif
    localparam int P        = SETTLE_CYC + K;
    localparam int SCAN_CYC = MUX_SZ * P;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic                    resp_ready = 1'b0;
    logic [N_BIT-1:0]        mux_in = '0;
    logic                    busy;
    logic [SEL_W-1:0]        sel_mux;
    logic [MUX_SZ*N_BIT-1:0] resp;
    logic                    resp_valid;
    logic [SEL_W:0]          unstable_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int scan_no  = 0;

    logic [2:0] fmask [MUX_SZ];
    logic [2:0] drove [MUX_SZ];

    puf_soc_resp_sampler #(
        .N_BIT      (N_BIT),
        .MUX_SZ     (MUX_SZ),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .o_busy         (busy),
        .o_sel_mux      (sel_mux),
        .i_mux          (mux_in),
        .o_resp         (resp),
        .o_resp_valid   (resp_valid),
        .i_resp_ready   (resp_ready),
        .o_unstable_cnt (unstable_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  64'(busy),         64'd0);
        check({tag, "_valid"}, 64'(resp_valid),   64'd0);
        check({tag, "_sel"},   64'(sel_mux),      64'd0);
        check({tag, "_resp"},  64'(resp),         64'd0);
        check({tag, "_unst"},  64'(unstable_cnt), 64'd0);
    endtask

    // One scan from IDLE. rst_at >= 0 aborts with a one-cycle reset at that cycle offset.
    task automatic run_scan(input logic [MUX_SZ-1:0] pat, input int ready_delay,
                            input int rst_at, input bit hold_start, input bit busy_starts);
        logic [MUX_SZ-1:0] exp_resp;
        logic [MUX_SZ-1:0] held_resp;
        int exp_unst;
        int rel;
        int ones;
        int c;
        int j;
        logic v;

        for (int i = 0; i < MUX_SZ; i++) drove[i] = 3'b000;
        start  = 1'b1;
        mux_in = N_BIT'($urandom);
        tick();
        if (!hold_start) start = 1'b0;
        check("busy_on_accept", 64'(busy), 64'd1);
        check("resp_cleared",   64'(resp), 64'd0);
        check("unst_cleared",   64'(unstable_cnt), 64'd0);

        for (int t = 0; t < SCAN_CYC; t++) begin
            check("sel_step",   64'(sel_mux),    64'(t / P));
            check("valid_low",  64'(resp_valid), 64'd0);
            check("busy_scan",  64'(busy),       64'd1);
            if (t == rst_at) begin
                rst_n = 1'b0;
                start = 1'b0;
                tick();
                check_all_zero("reset_mid_scan");
                rst_n = 1'b1;
                $display("scan %0d: aborted by reset at sel %0d", scan_no, rst_at / P);
                scan_no++;
                return;
            end
            // Value presented for the next edge: the channel's bit inside its sample
            // window (optionally flipped), random garbage outside it
            rel = t + 1 - (SETTLE_CYC + 1);
            mux_in = N_BIT'($urandom);
            if (rel >= 0) begin
                c = rel / P;
                j = rel % P;
                if (c < MUX_SZ && j < K) begin
                    v = pat[sel_mux] ^ fmask[c][j];
                    mux_in = v;
                    drove[c][j] = v;
                end
            end
            if (busy_starts && !hold_start) start = ($urandom_range(0, 3) == 0);
            resp_ready = ($urandom_range(0, 1) == 1);
            tick();
        end
        resp_ready = 1'b0;
        start = hold_start;

        exp_resp = '0;
        exp_unst = 0;
        for (int ch = 0; ch < MUX_SZ; ch++) begin
            ones = 0;
            for (int s = 0; s < K; s++) ones += int'(drove[ch][s]);
            exp_resp[ch] = (2 * ones > K);
            if (K == 3 && ones != 0 && ones != K) exp_unst++;
        end

        check("valid_at_latency", 64'(resp_valid),   64'd1);
        check("resp_word",        64'(resp),         64'(exp_resp));
        check("unstable_cnt",     64'(unstable_cnt), 64'(exp_unst));
        check("sel_last",         64'(sel_mux),      64'(MUX_SZ - 1));
        $display("scan %0d: pattern=%h resp=%h expected=%h unstable=%0d ready_delay=%0d",
                 scan_no, pat, resp, exp_resp, unstable_cnt, ready_delay);
        scan_no++;
        held_resp = resp;

        for (int d = 0; d < ready_delay; d++) begin
            if (!hold_start) start = ($urandom_range(0, 1) == 1);
            tick();
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_resp",  64'(resp),       64'(exp_resp));
            check("bp_busy",  64'(busy),       64'd1);
        end
        start      = hold_start;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("hs_valid", 64'(resp_valid), 64'd0);
        check("hs_busy",  64'(busy),       64'd0);
        check("hs_sel",   64'(sel_mux),    64'd0);
        check("hs_resp",  64'(resp),       64'(held_resp));

        if (hold_start) begin
            tick();
            check("retrigger_busy", 64'(busy), 64'd1);
            check("retrigger_resp", 64'(resp), 64'd0);
            start = 1'b0;
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            check_all_zero("retrigger_reset");
        end else begin
            tick();
            check("idle_resp_hold", 64'(resp), 64'(held_resp));
            check("idle_busy",      64'(busy), 64'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < MUX_SZ; i++) fmask[i] = 3'b000;
        rst_n = 1'b0;
        start = 1'b1;
        resp_ready = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        check_all_zero("idle_ready_ignored");
        resp_ready = 1'b0;

        run_scan(16'hA5C3, 0,  -1, 1'b0, 1'b0);
        run_scan(16'hA5C3, 10, -1, 1'b0, 1'b1);
        run_scan(16'hA5C3, 1,  7 * P + 1, 1'b0, 1'b0);
        run_scan(16'hA5C3, 0,  -1, 1'b0, 1'b0);
        run_scan(16'($urandom), 2, -1, 1'b1, 1'b0);

`ifdef PUF_SOC_MAJ_VOTE_EN
        fmask[3] = 3'b101;
        run_scan(16'hA5C3, 0, -1, 1'b0, 1'b0);
        check("vote_ch3_bit", 64'(resp[3]), 64'd1);
        check("vote_unst_one", 64'(unstable_cnt), 64'd1);
        fmask[3] = 3'b000;
`endif

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < MUX_SZ; i++) begin
                fmask[i] = 3'b000;
                if (K == 3 && $urandom_range(0, 1) == 1) fmask[i][$urandom_range(0, 2)] = 1'b1;
            end
            run_scan(16'($urandom), $urandom_range(0, 6), -1, 1'b0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
